// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_share_arbiter                                            |
// | Description : Shares one DW-bit ALU between two requesters. One op is      |
// |               granted per cycle. The granted requester's fields drive the  |
// |               ALU operands combinationally. The ALU result and its {N,Z,V}  |
// |               flags land in a single-entry response register that has      |
// |               valid/ready backpressure. A {N,Z,V} condition-code register  |
// |               is kept per requester.                                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst_n           clock (rising edge); async active-low reset          |
// |   req_valid/req_ready  per-requester handshake, bit i = requester i        |
// |   reqN_op/a/b/imm      opcode, operands and shift amount of requester N     |
// |   alu_in1/in2/imm/op   operands to the shared ALU (from granted requester)  |
// |   alu_out, alu_n/z/v   result and flags returned by the ALU                 |
// |   rsp_valid/rsp_ready  response register handshake                         |
// |   rsp_data/id/flags    registered result, issuing requester, {N,Z,V}        |
// |   cc0, cc1             {N,Z,V} of the last result issued by requester 0/1   |
// +----------------------------------------------------------------------------+
module alu_share_arbiter #(
    parameter int DW    = 16,
    parameter int RR_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [2:0]    req0_op,
    input  logic [2:0]    req1_op,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req0_b,
    input  logic [DW-1:0] req1_b,
    input  logic [3:0]    req0_imm,
    input  logic [3:0]    req1_imm,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [3:0]    alu_imm,
    output logic [2:0]    alu_opcode,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_n,
    input  logic          alu_z,
    input  logic          alu_v,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_id,
    output logic [2:0]    rsp_flags,
    output logic [2:0]    cc0,
    output logic [2:0]    cc1
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

    rsp_state_t    r_state;
    rsp_state_t    w_state_nxt;

    logic [1:0]    w_grant;
    logic          w_accept_ok;
    logic          w_hs;
    logic          w_hs_id;
    logic [2:0]    w_alu_flags;

    logic          r_last_grant;
    logic [DW-1:0] r_data;
    logic [2:0]    r_flags;
    logic          r_id;
    logic [2:0]    r_cc0;
    logic [2:0]    r_cc1;

    // Grant depends only on the valids and the last completed winner, never on
    // backpressure, so a stalled grant keeps its place until it completes.
    always_comb begin
        w_grant = 2'b00;
        case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11: begin
                if (RR_EN != 0) begin
                    w_grant = r_last_grant ? 2'b01 : 2'b10;
                end else begin
                    w_grant = 2'b01;
                end
            end
            default: w_grant = 2'b00;
        endcase
    end

    // The response register can take a new result when it is empty or is
    // being drained in this same cycle.
    assign w_accept_ok = (r_state == ST_EMPTY) | rsp_ready;
    assign req_ready   = w_grant & {2{w_accept_ok}};
    assign w_hs        = |req_ready;
    assign w_hs_id     = req_ready[1];
    assign w_alu_flags = {alu_n, alu_z, alu_v};

    // With no grant the mux rests on requester 0, keeping the ALU inputs stable.
    always_comb begin
        alu_in1    = req0_a;
        alu_in2    = req0_b;
        alu_imm    = req0_imm;
        alu_opcode = req0_op;
        if (w_grant[1]) begin
            alu_in1    = req1_a;
            alu_in2    = req1_b;
            alu_imm    = req1_imm;
            alu_opcode = req1_op;
        end
    end

    // Response register occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_hs) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                // A capture in the draining cycle replaces the old result.
                if (rsp_ready && !w_hs) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Payload, arbitration history and condition codes all move only on a
    // completed handshake; a drain leaves the payload as it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_flags      <= 3'b000;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_cc0        <= 3'b000;
            r_cc1        <= 3'b000;
        end else if (w_hs) begin
            r_data       <= alu_out;
            r_flags      <= w_alu_flags;
            r_id         <= w_hs_id;
            r_last_grant <= w_hs_id;
            if (w_hs_id) begin
                r_cc1 <= w_alu_flags;
            end else begin
                r_cc0 <= w_alu_flags;
            end
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;
    assign rsp_flags = r_flags;
    assign cc0       = r_cc0;
    assign cc1       = r_cc1;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_share_arbiter                                         |
// | Description : Self-checking bench. Two instances share one stimulus:       |
// |               index 0 is fixed priority (RR_EN=0), index 1 is round-robin. |
// |               A behavioural ALU answers each instance, and a transaction-  |
// |               level model predicts grants and response/cc contents.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [2:0]  op [2];
    logic [15:0] a [2];
    logic [15:0] b [2];
    logic [3:0]  imm [2];
    logic        rsp_ready;

    logic [1:0]  d_req_ready [2];
    logic [15:0] d_alu_in1 [2];
    logic [15:0] d_alu_in2 [2];
    logic [3:0]  d_alu_imm [2];
    logic [2:0]  d_alu_opcode [2];
    logic [15:0] d_alu_out [2];
    logic        d_alu_n [2];
    logic        d_alu_z [2];
    logic        d_alu_v [2];
    logic        d_rsp_valid [2];
    logic [15:0] d_rsp_data [2];
    logic        d_rsp_id [2];
    logic [2:0]  d_rsp_flags [2];
    logic [2:0]  d_cc0 [2];
    logic [2:0]  d_cc1 [2];

    int n_chk = 0;
    int n_err = 0;

    // Model state per instance
    bit          m_full [2];
    logic [15:0] m_data [2];
    logic [2:0]  m_flags [2];
    bit          m_id [2];
    bit          m_last [2];
    logic [2:0]  m_cc [2][2];
    int          e_win [2];
    bit          e_hs [2];
    bit          hold [2];

    // Signed-saturating ALU: returns {result, N, Z, V}
    function automatic logic [18:0] alu_ref(input logic [2:0] f_op, input logic [15:0] x,
                                            input logic [15:0] y, input logic [3:0] sh);
        logic [15:0] r;
        logic [15:0] s;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic        v;
        logic        vl;
        logic        vh;
        v = 1'b0;
        case (f_op)
            3'd0: begin
                s = x + y;
                v = (x[15] == y[15]) && (s[15] != x[15]);
                r = v ? (x[15] ? 16'h8000 : 16'h7FFF) : s;
            end
            3'd1: begin
                lo = x[7:0] + y[7:0];
                hi = x[15:8] + y[15:8];
                vl = (x[7] == y[7]) && (lo[7] != x[7]);
                vh = (x[15] == y[15]) && (hi[7] != x[15]);
                if (vl) lo = x[7] ? 8'h80 : 8'h7F;
                if (vh) hi = x[15] ? 8'h80 : 8'h7F;
                r = {hi, lo};
                v = vl | vh;
            end
            3'd2: begin
                s = x - y;
                v = (x[15] != y[15]) && (s[15] != x[15]);
                r = v ? (x[15] ? 16'h8000 : 16'h7FFF) : s;
            end
            3'd3:    r = ~(x & y);
            3'd4:    r = x ^ y;
            3'd5:    r = x << sh;
            3'd6:    r = x >> sh;
            3'd7:    r = $unsigned($signed(x) >>> sh);
            default: r = x;
        endcase
        return {r, r[15], (r == 16'h0000), v};
    endfunction

    assign {d_alu_out[0], d_alu_n[0], d_alu_z[0], d_alu_v[0]} =
        alu_ref(d_alu_opcode[0], d_alu_in1[0], d_alu_in2[0], d_alu_imm[0]);
    assign {d_alu_out[1], d_alu_n[1], d_alu_z[1], d_alu_v[1]} =
        alu_ref(d_alu_opcode[1], d_alu_in1[1], d_alu_in2[1], d_alu_imm[1]);

    alu_share_arbiter #(.DW(16), .RR_EN(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(d_req_ready[0]),
        .req0_op(op[0]), .req1_op(op[1]), .req0_a(a[0]), .req1_a(a[1]),
        .req0_b(b[0]), .req1_b(b[1]), .req0_imm(imm[0]), .req1_imm(imm[1]),
        .alu_in1(d_alu_in1[0]), .alu_in2(d_alu_in2[0]), .alu_imm(d_alu_imm[0]),
        .alu_opcode(d_alu_opcode[0]), .alu_out(d_alu_out[0]),
        .alu_n(d_alu_n[0]), .alu_z(d_alu_z[0]), .alu_v(d_alu_v[0]),
        .rsp_valid(d_rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_data(d_rsp_data[0]),
        .rsp_id(d_rsp_id[0]), .rsp_flags(d_rsp_flags[0]), .cc0(d_cc0[0]), .cc1(d_cc1[0])
    );

    alu_share_arbiter #(.DW(16), .RR_EN(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(d_req_ready[1]),
        .req0_op(op[0]), .req1_op(op[1]), .req0_a(a[0]), .req1_a(a[1]),
        .req0_b(b[0]), .req1_b(b[1]), .req0_imm(imm[0]), .req1_imm(imm[1]),
        .alu_in1(d_alu_in1[1]), .alu_in2(d_alu_in2[1]), .alu_imm(d_alu_imm[1]),
        .alu_opcode(d_alu_opcode[1]), .alu_out(d_alu_out[1]),
        .alu_n(d_alu_n[1]), .alu_z(d_alu_z[1]), .alu_v(d_alu_v[1]),
        .rsp_valid(d_rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_data(d_rsp_data[1]),
        .rsp_id(d_rsp_id[1]), .rsp_flags(d_rsp_flags[1]), .cc0(d_cc0[1]), .cc1(d_cc1[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Winner from the arbitration rules: index 1 is round-robin, index 0 fixed.
    function automatic int winner(input int k);
        if (req_valid == 2'b00) return -1;
        if (req_valid == 2'b01) return 0;
        if (req_valid == 2'b10) return 1;
        if (k == 1) return m_last[k] ? 0 : 1;
        return 0;
    endfunction

    task automatic check_regs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rsp_valid%0d", k), 32'(d_rsp_valid[k]), 32'(m_full[k]));
            chk($sformatf("rsp_data%0d", k),  32'(d_rsp_data[k]),  32'(m_data[k]));
            chk($sformatf("rsp_id%0d", k),    32'(d_rsp_id[k]),    32'(m_id[k]));
            chk($sformatf("rsp_flags%0d", k), 32'(d_rsp_flags[k]), 32'(m_flags[k]));
            chk($sformatf("cc0_%0d", k),      32'(d_cc0[k]),       32'(m_cc[k][0]));
            chk($sformatf("cc1_%0d", k),      32'(d_cc1[k]),       32'(m_cc[k][1]));
        end
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model at
    // the edge, then check registered outputs. Inputs must be set by caller.
    task automatic cycle();
        logic [1:0]  exp_rdy;
        logic [18:0] r;
        int          w;
        int          s;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            w = winner(k);
            e_win[k] = w;
            e_hs[k]  = (w >= 0) && (!m_full[k] || rsp_ready);
            exp_rdy  = e_hs[k] ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
            s = (w == 1) ? 1 : 0;
            chk($sformatf("req_ready%0d", k), 32'(d_req_ready[k]), 32'(exp_rdy));
            chk($sformatf("alu_op%0d", k),    32'(d_alu_opcode[k]), 32'(op[s]));
            chk($sformatf("alu_in1_%0d", k),  32'(d_alu_in1[k]),   32'(a[s]));
            chk($sformatf("alu_in2_%0d", k),  32'(d_alu_in2[k]),   32'(b[s]));
            chk($sformatf("alu_imm%0d", k),   32'(d_alu_imm[k]),   32'(imm[s]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (e_hs[k]) begin
                w = e_win[k];
                r = alu_ref(op[w], a[w], b[w], imm[w]);
                m_full[k]    = 1'b1;
                m_data[k]    = r[18:3];
                m_flags[k]   = r[2:0];
                m_id[k]      = (w == 1);
                m_last[k]    = (w == 1);
                m_cc[k][w]   = r[2:0];
            end else if (m_full[k] && rsp_ready) begin
                m_full[k] = 1'b0;
            end
        end
        #1;
        check_regs();
    endtask

    // Async reset asserted between edges; state is checked before any edge.
    task automatic do_reset();
        req_valid = 2'b00;
        rst_n     = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            m_full[k]  = 1'b0;
            m_data[k]  = 16'h0000;
            m_flags[k] = 3'b000;
            m_id[k]    = 1'b0;
            m_last[k]  = 1'b1;
            m_cc[k][0] = 3'b000;
            m_cc[k][1] = 3'b000;
            e_hs[k]    = 1'b0;
        end
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            3:       return 16'h7F80;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [2:0] save_cc0 [2];
        rst_n     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            op[i] = 3'd0; a[i] = 16'h0; b[i] = 16'h0; imm[i] = 4'h0; hold[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        do_reset();

        // T1: saturating add, latency one
        req_valid = 2'b01;
        op[0] = 3'd0; a[0] = 16'h7000; b[0] = 16'h2000; imm[0] = 4'h0;
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("t1_data",  32'(d_rsp_data[k]),  32'h7FFF);
            chk("t1_flags", 32'(d_rsp_flags[k]), 32'h1);
            chk("t1_id",    32'(d_rsp_id[k]),    32'h0);
            chk("t1_cc0",   32'(d_cc0[k]),       32'h1);
        end
        req_valid = 2'b00;
        cycle();

        // T2: round-robin alternation starting at requester 0
        do_reset();
        req_valid = 2'b11;
        op[0] = 3'd4; a[0] = 16'h00FF; b[0] = 16'h0F0F;
        op[1] = 3'd5; a[1] = 16'h0003; b[1] = 16'h0000; imm[1] = 4'h2;
        for (int n = 0; n < 6; n++) begin
            cycle();
            chk("t2_rr_id", 32'(d_rsp_id[1]), 32'(n % 2));
        end

        // T3: fixed priority starves requester 1 until requester 0 drops
        do_reset();
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            cycle();
            chk("t3_fp_rdy", 32'(d_req_ready[0]), 32'h1);
            chk("t3_fp_id",  32'(d_rsp_id[0]),    32'h0);
        end
        req_valid = 2'b10;
        cycle();
        chk("t3_fp_req1", 32'(d_rsp_id[0]), 32'h1);

        // T4: backpressure holds response; release captures in drain cycle
        req_valid = 2'b01;
        op[0] = 3'd3; a[0] = 16'hF0F0; b[0] = 16'hFF00;
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        op[1] = 3'd4; a[1] = 16'h1111; b[1] = 16'h0101;
        for (int n = 0; n < 3; n++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                chk("t4_stall_rdy",  32'(d_req_ready[k]), 32'h0);
                chk("t4_stall_data", 32'(d_rsp_data[k]),  32'h0FFF);
            end
        end
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) chk("t4_release_rdy", 32'(d_req_ready[k]), 32'h2);
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("t4_new_valid", 32'(d_rsp_valid[k]), 32'h1);
            chk("t4_new_data",  32'(d_rsp_data[k]),  32'h1010);
        end

        // T5: XOR to zero on requester 1 leaves cc0 alone
        req_valid = 2'b10;
        op[1] = 3'd4; a[1] = 16'h1234; b[1] = 16'h1234;
        for (int k = 0; k < 2; k++) save_cc0[k] = m_cc[k][0];
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("t5_data",  32'(d_rsp_data[k]),  32'h0);
            chk("t5_flags", 32'(d_rsp_flags[k]), 32'h2);
            chk("t5_cc1",   32'(d_cc1[k]),       32'h2);
            chk("t5_cc0",   32'(d_cc0[k]),       32'(save_cc0[k]));
        end

        // T6: reset with a pending response, then first RR grant goes to 0
        req_valid = 2'b01;
        op[0] = 3'd5; a[0] = 16'h0001; imm[0] = 4'h4;
        rsp_ready = 1'b0;
        cycle();
        for (int k = 0; k < 2; k++) chk("t6_pending", 32'(d_rsp_valid[k]), 32'h1);
        do_reset();
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        chk("t6_first_grant", 32'(d_req_ready[1]), 32'h1);
        cycle();
        chk("t6_first_id", 32'(d_rsp_id[1]), 32'h0);

        // Randomized traffic with protocol-respecting hold behaviour
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                hold[0] = 1'b0;
                hold[1] = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (!hold[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 70);
                    op[i]  = 3'($urandom);
                    a[i]   = rand_word();
                    b[i]   = rand_word();
                    imm[i] = 4'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            for (int i = 0; i < 2; i++) begin
                hold[i] = req_valid[i] &&
                          !(e_hs[0] && e_win[0] == i && e_hs[1] && e_win[1] == i);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
